// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back port.
package wb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } wb_entry_t;

endpackage

// File: rtl/wb_kill_fifo.sv
// Circular buffer of queued write-backs with kill-by-address and a pending-register mask.
module wb_kill_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  wb_entry_t   push_entry,
    input  logic        pop,
    input  logic        kill,
    input  logic [4:0]  kill_wa,
    output wb_entry_t   head,
    output logic [31:0] pending,
    output logic        full,
    output logic        empty
);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // NOTE: storage has no reset; liveness comes from the pointers and count, so stale slots never leak out.
    always_ff @(posedge clk) begin
        if (kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem[i].wa == kill_wa) mem[i].wa <= REG_ZERO;
            end
        end
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    // Only slots within [rd_ptr, rd_ptr+count) are live; killed entries carry wa=0.
    always_comb begin
        logic [AW-1:0] off;
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr;
            if ({1'b0, off} < count) pending = pending | (32'd1 << mem[i].wa);
        end
        pending[0] = 1'b0;
    end

endmodule

// File: rtl/wb_write_port.sv
// Register-file write port: pipeline writes win, buffered MDU results fill idle cycles.
module wb_write_port
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_wa,
    input  logic [31:0] mdu_wd,
    input  logic [31:0] mdu_pc,
    output logic [4:0]  WA,
    output logic [31:0] WD,
    output logic [31:0] PC_W,
    output logic [31:0] pending,
    output logic        full,
    output logic        empty
);

    logic      pipe_write;
    logic      push;
    logic      pop;
    wb_entry_t head;

    assign pipe_write = (pipe_wa != REG_ZERO);
    assign mdu_ready  = !full;
    assign pop        = !pipe_write && !empty;
    // Results for $0, or already overwritten by a same-cycle pipeline write, are acknowledged and dropped.
    assign push = mdu_valid && mdu_ready && (mdu_wa != REG_ZERO)
               && !(pipe_write && (mdu_wa == pipe_wa));

    wb_kill_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry ('{wa: mdu_wa, wd: mdu_wd, pc: mdu_pc}),
        .pop        (pop),
        .kill       (pipe_write),
        .kill_wa    (pipe_wa),
        .head       (head),
        .pending    (pending),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WA   <= REG_ZERO;
            WD   <= '0;
            PC_W <= '0;
        end else if (pipe_write) begin
            WA   <= pipe_wa;
            WD   <= pipe_wd;
            PC_W <= pipe_pc;
        end else if (!empty) begin
            WA   <= head.wa;
            WD   <= head.wd;
            PC_W <= head.pc;
        end else begin
            WA   <= REG_ZERO;
        end
    end

endmodule

// File: tb/tb_wb_write_port.sv
// Directed self-checking bench for wb_write_port.
module tb_wb_write_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd, pipe_pc;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_wa;
    logic [31:0] mdu_wd, mdu_pc;
    logic [4:0]  WA;
    logic [31:0] WD, PC_W, pending;
    logic        full, empty;

    int checks = 0;
    int failures = 0;

    wb_write_port #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_wa   (pipe_wa),
        .pipe_wd   (pipe_wd),
        .pipe_pc   (pipe_pc),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_wa    (mdu_wa),
        .mdu_wd    (mdu_wd),
        .mdu_pc    (mdu_pc),
        .WA        (WA),
        .WD        (WD),
        .PC_W      (PC_W),
        .pending   (pending),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
        pipe_wa = wa;
        pipe_wd = wd;
        pipe_pc = pc;
    endtask

    task automatic set_mdu(input logic v, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
        mdu_valid = v;
        mdu_wa    = wa;
        mdu_wd    = wd;
        mdu_pc    = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_pipe(5'd0, 32'd0, 32'd0);
        set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
        #12;
        reset = 1'b0;
        #1;
        check("rst_wa", 32'(WA), 32'd0);
        check("rst_wd", WD, 32'd0);
        check("rst_pc", PC_W, 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_ready", 32'(mdu_ready), 32'd1);

        // Pipeline write, one-cycle latency, then WA returns to 0 while WD holds.
        step();
        set_pipe(5'd5, 32'h11, 32'h3000);
        step();
        check("pipe_wa", 32'(WA), 32'd5);
        check("pipe_wd", WD, 32'h11);
        check("pipe_pc", PC_W, 32'h3000);
        set_pipe(5'd0, 32'd0, 32'd0);
        step();
        check("idle_wa", 32'(WA), 32'd0);
        check("idle_wd_hold", WD, 32'h11);

        // Single MDU result: enqueued, then drained on the next idle edge.
        set_mdu(1'b1, 5'd8, 32'hAB, 32'h3010);
        step();
        set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
        check("mdu_q_pending", pending, 32'h0000_0100);
        check("mdu_q_wa", 32'(WA), 32'd0);
        step();
        check("mdu_drain_wa", 32'(WA), 32'd8);
        check("mdu_drain_wd", WD, 32'hAB);
        check("mdu_drain_pc", PC_W, 32'h3010);
        check("mdu_drain_pending", pending, 32'd0);
        check("mdu_drain_empty", 32'(empty), 32'd1);

        // Pipeline busy for 6 cycles while MDU offers 9..13; only 4 fit.
        set_pipe(5'd3, 32'h33, 32'h3020);
        for (int k = 0; k < 6; k++) begin
            if (k < 5) set_mdu(1'b1, 5'(9 + k), 32'h900 + 32'(9 + k), 32'h4000 + 32'(k));
            else       set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
            check($sformatf("fill_ready_%0d", k), 32'(mdu_ready), (k < 4) ? 32'd1 : 32'd0);
            step();
            check($sformatf("fill_wa_%0d", k), 32'(WA), 32'd3);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_pending", pending, 32'h0000_1E00);
        set_pipe(5'd0, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("drain_wa_%0d", k), 32'(WA), 32'(9 + k));
            check($sformatf("drain_wd_%0d", k), WD, 32'h900 + 32'(9 + k));
        end
        check("drain_empty", 32'(empty), 32'd1);
        step();
        check("drain_done_wa", 32'(WA), 32'd0);

        // Queued write to $7 killed by a newer pipeline write to $7.
        set_mdu(1'b1, 5'd7, 32'd1, 32'h3030);
        step();
        set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
        check("kill_pre_pending", pending, 32'h0000_0080);
        set_pipe(5'd7, 32'd2, 32'h3040);
        step();
        check("kill_pipe_wa", 32'(WA), 32'd7);
        check("kill_pipe_wd", WD, 32'd2);
        check("kill_pending", pending, 32'd0);
        check("kill_bubble_kept", 32'(empty), 32'd0);
        set_pipe(5'd0, 32'd0, 32'd0);
        step();
        check("bubble_wa", 32'(WA), 32'd0);
        check("bubble_wd", WD, 32'd1);
        check("bubble_empty", 32'(empty), 32'd1);

        // Same-cycle MDU and pipeline writes to $4: pipeline wins, MDU dropped.
        set_mdu(1'b1, 5'd4, 32'h99, 32'h3058);
        set_pipe(5'd4, 32'h55, 32'h3050);
        check("same_ready", 32'(mdu_ready), 32'd1);
        step();
        set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
        set_pipe(5'd0, 32'd0, 32'd0);
        check("same_wa", 32'(WA), 32'd4);
        check("same_wd", WD, 32'h55);
        check("same_pending", pending, 32'd0);
        check("same_empty", 32'(empty), 32'd1);
        step();
        check("same_after_wa", 32'(WA), 32'd0);
        check("same_after_wd", WD, 32'h55);

        // Async reset mid-cycle with three entries queued.
        set_pipe(5'd1, 32'h77, 32'h3060);
        for (int k = 0; k < 3; k++) begin
            set_mdu(1'b1, 5'(20 + k), 32'h20 + 32'(k), 32'h5000);
            step();
        end
        set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
        check("prerst_pending", pending, 32'h0070_0000);
        check("prerst_wa", 32'(WA), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_wa", 32'(WA), 32'd0);
        check("arst_wd", WD, 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_full", 32'(full), 32'd0);
        check("arst_pending", pending, 32'd0);
        check("arst_ready", 32'(mdu_ready), 32'd1);
        set_pipe(5'd0, 32'd0, 32'd0);
        #3;
        reset = 1'b0;
        step();
        check("postrst_wa", 32'(WA), 32'd0);
        check("postrst_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_write_port.md
Name: wb_write_port

Overview:
Write-back producer for the register file write port (WA/WD/PC_W, where WA=0 means "no write"). Merges two write sources: the W-stage pipeline write, which is never stalled and always has priority, and a multi-cycle MDU result stream with a valid/ready handshake. MDU results are buffered in a small FIFO and drained into idle write-port cycles. The block also exports a pending-register mask so the hazard unit can stall readers of registers with queued writes.

Parameters:
DEPTH, 4, MDU result FIFO entries; power of two, >=2
AW, 2, pointer width, log2(DEPTH)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
pipe_wa  in  5  W-stage destination register; 0 = no pipeline write this cycle
pipe_wd  in  32  W-stage write data
pipe_pc  in  32  W-stage instruction PC
mdu_valid  in  1  MDU result offered
mdu_ready  out  1  FIFO can accept; equals !full
mdu_wa  in  5  MDU destination register
mdu_wd  in  32  MDU result data
mdu_pc  in  32  PC of the MDU-issuing instruction
WA  out  5  RF write address, registered; 0 = no write
WD  out  32  RF write data, registered
PC_W  out  32  PC of the write, registered, for the trace display
pending  out  32  bit r = 1 iff a live queued entry targets $r
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries

Behaviour:
- Reset (async, any time, including mid-drain) has these effects:
  - WA=0, WD=0, PC_W=0.
  - FIFO emptied and pointers set to 0, so empty=1, full=0, pending=0, mdu_ready=1.
  - Queued entries are discarded.
- Output register, one-cycle latency. At each posedge:
  - If pipe_wa!=0: WA/WD/PC_W <= pipe_wa/pipe_wd/pipe_pc. The FIFO does not pop.
  - Else, if the FIFO is non-empty: pop the head and WA/WD/PC_W <= head fields. A killed head has wa=0, so its pop yields WA=0.
  - Else: WA <= 0. WD and PC_W hold their values.
- Push: occurs at a posedge with mdu_valid && mdu_ready.
  - mdu_wa==0 is accepted (handshake completes) but not enqueued.
  - mdu_ready = !full, purely from state. A full FIFO refuses a push even when it pops in the same cycle.
  - When not full, push and pop in the same cycle are both performed, and the count is unchanged.
- Kill (WAW ordering; the pipeline write is always the newer one):
  - At a posedge with pipe_wa!=0, every stored entry with wa==pipe_wa has its wa set to 0. The entry remains in the FIFO as a bubble.
  - A same-cycle MDU push with mdu_wa==pipe_wa is accepted but not enqueued.
- pending is combinational from state: OR over stored entries of onehot(wa), and bit 0 is forced to 0. Killed entries contribute nothing.
- Pointers wrap modulo DEPTH. Count width is AW+1. full=(count==DEPTH), empty=(count==0).
- The block has no internal $0 check beyond the rules above. The RF ignores WA=0.

Decomposition:
- Shared package (wb_pkg):
  - REG_ZERO = 5'd0.
  - wb_entry_t {wa[4:0], wd[31:0], pc[31:0]}.
  - Default DEPTH.
- Sub-module wb_kill_fifo: circular buffer of wb_entry_t with push/pop, a kill-by-address input, a pending-mask output, and full/empty.
- The top level holds the source arbitration and the output register.

Test Plan:
- Reset, then pipe_wa=5, wd=0x11, pc=0x3000 for 1 cycle -> next cycle WA=5, WD=0x11, PC_W=0x3000; following cycle WA=0.
- With pipe_wa=0, push MDU {wa=8, wd=0xAB, pc=0x3010} -> enqueued at edge 1, pending[8]=1 after it; popped at edge 2, so WA=8, WD=0xAB after edge 2 and pending=0.
- Hold pipe_wa=3 for 6 cycles while pushing 5 MDU results with wa=9..13 -> mdu_ready drops after 4 accepts, full=1, WA=3 every cycle; on release the FIFO drains 9,10,11,12 in order on consecutive cycles.
- Queue {wa=7, wd=1}, then pipe_wa=7, wd=2 before the drain -> WA=7, WD=2 once; the later FIFO pop gives WA=0; pending[7] clears after the pipeline edge.
- Same cycle: mdu_valid with wa=4, pipe_wa=4, wd=0x55 -> handshake accepted, no enqueue, pending[4]=0, WA=4, WD=0x55 only.
- Assert reset asynchronously mid-clock with 3 entries queued -> WA=0, empty=1, pending=0, mdu_ready=1 immediately, without waiting for a clock edge.
